// File: rtl/i2c_reg_pkg.sv
// Shared types and constants for the I2C register target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_reg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  localparam logic [7:0] REG_CMP_L   = 8'd0;
  localparam logic [7:0] REG_CMP_M   = 8'd1;
  localparam logic [7:0] REG_CMP_H   = 8'd2;
  localparam logic [7:0] REG_CTRL    = 8'd3;
  localparam int         NUM_REGS    = 4;
  localparam logic [7:0] RD_UNMAPPED = 8'hFF;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw bus line and debounces it with a stability filter.
// Latency: 2 sync flops + FILT_LEN equal samples before lvl/rise/fall move.
// Backpressure: none; strobes are single-clk pulses aligned with the lvl change.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      lvl  <= 1'b1;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        lvl  <= sync[1];
        cnt  <= '0;
        rise <= sync[1];
        fall <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with auto-incrementing pointer, staged compare value and atomic publish.
// Latency: filter delay after each SCL edge; commit lands on the clk of the 8th bit of reg 3.
// Backpressure: none; SCL is never stretched, every addressed byte is ACKed.
module i2c_reg_target
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h52,
  parameter int         FILT_LEN = 3,
  parameter int         CMP_W    = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [CMP_W-1:0] cmpa,
  output logic             cmpa_valid,
  output logic [7:0]       ctrl,
  output logic             busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (scl_i),
    .lvl  (scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (sda_i),
    .lvl  (sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       ptr;
  logic             rw;
  logic [CMP_W-1:0] stage;
  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;

  // Byte as it stands once the bit currently on SDA is shifted in.
  assign byte_in = {shreg[6:0], sda_lvl};

  // Read mux: staged value for the compare bytes, published ctrl, 0xFF when unmapped.
  always_comb begin
    rd_byte = RD_UNMAPPED;
    case (ptr)
      REG_CMP_L: rd_byte = stage[7:0];
      REG_CMP_M: rd_byte = stage[15:8];
      REG_CMP_H: rd_byte = {{(24 - CMP_W){1'b0}}, stage[CMP_W-1:16]};
      REG_CTRL:  rd_byte = ctrl;
      default:   rd_byte = RD_UNMAPPED;
    endcase
  end

  // Protocol FSM: bus conditions first, bits sampled on SCL rise, SDA driven only after SCL fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      stage      <= '0;
      cmpa       <= '0;
      ctrl       <= '0;
      cmpa_valid <= 1'b0;
      busy       <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      cmpa_valid <= 1'b0;
      if (sda_fall && scl_lvl) begin
        // START or repeated START; ptr deliberately survives
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (sda_rise && scl_lvl) begin
        // STOP drops any partial byte without writing
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (byte_in[7:1] == I2C_ADDR) begin
                state <= ADDR_ACK;
                rw    <= byte_in[0];
                busy  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          PTR: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr   <= byte_in;
              state <= PTR_ACK;
            end
          end
          WDATA: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= WDATA_ACK;
              case (ptr)
                REG_CMP_L: stage[7:0]         <= byte_in;
                REG_CMP_M: stage[15:8]        <= byte_in;
                REG_CMP_H: stage[CMP_W-1:16]  <= byte_in[CMP_W-17:0];
                REG_CTRL: begin
                  cmpa       <= stage;
                  ctrl       <= byte_in;
                  cmpa_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA: bit_cnt <= bit_cnt + 4'd1;
          RACK: begin
            if (sda_lvl) begin
              state <= IGNORE;
            end else begin
              ptr     <= ptr + 8'd1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
            end else if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              if (state == ADDR_ACK && rw) begin
                shreg  <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= RDATA;
              end else if (state == ADDR_ACK) begin
                state <= PTR;
              end else if (state == PTR_ACK) begin
                state <= WDATA;
              end else begin
                state <= WDATA;
                ptr   <= ptr + 8'd1;
              end
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RACK;
            end else if (bit_cnt != 4'd0) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          RACK: begin
            if (bit_cnt == 4'd9) begin
              shreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
